// File: rtl/slp_pkg.sv
// -----------------------------------------------------------------------------
// slp_pkg
// Shared types for the bit-serial logic processor: function-select codes,
// routing-select codes, FSM states and the single-bit logic function that
// the serial datapath applies to each (a0, b0) pair.
// -----------------------------------------------------------------------------
package slp_pkg;

   typedef enum logic [2:0] {
      F_AND  = 3'b000,
      F_OR   = 3'b001,
      F_XOR  = 3'b010,
      F_ONE  = 3'b011,
      F_NAND = 3'b100,
      F_NOR  = 3'b101,
      F_XNOR = 3'b110,
      F_ZERO = 3'b111
   } func_e;

   // Each code names what the shifted-in bit pair (ina, inb) is.
   typedef enum logic [1:0] {
      R_ROT  = 2'b00,  // (a0, b0)  rotate both registers
      R_TO_B = 2'b01,  // (a0, f)   result lands in B
      R_TO_A = 2'b10,  // (f,  b0)  result lands in A
      R_SWAP = 2'b11   // (b0, a0)  exchange A and B
   } route_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_HOLD  = 2'b10
   } state_e;

   function automatic logic slp_logic_fn(input func_e f, input logic a, input logic b);
      case (f)
         F_AND:   return a & b;
         F_OR:    return a | b;
         F_XOR:   return a ^ b;
         F_ONE:   return 1'b1;
         F_NAND:  return ~(a & b);
         F_NOR:   return ~(a | b);
         F_XNOR:  return ~(a ^ b);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/serial_compute_route.sv
// -----------------------------------------------------------------------------
// serial_compute_route
// Combinational per-bit stage: evaluates the selected logic function on the
// current LSBs of A and B and chooses the bits shifted into the MSBs.
// Ports:
//   a0, b0  in   current LSBs of A and B
//   F       in   latched function select
//   R       in   latched routing select
//   ina     out  bit shifted into A[WIDTH-1]
//   inb     out  bit shifted into B[WIDTH-1]
// -----------------------------------------------------------------------------
module serial_compute_route
   import slp_pkg::*;
(
   input  logic   a0,
   input  logic   b0,
   input  func_e  F,
   input  route_e R,
   output logic   ina,
   output logic   inb
);

   logic f;

   always_comb begin
      f   = slp_logic_fn(F, a0, b0);
      ina = a0;
      inb = b0;
      case (R)
         R_TO_B: inb = f;
         R_TO_A: ina = f;
         R_SWAP: begin
            ina = b0;
            inb = a0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/serial_logic_processor.sv
// -----------------------------------------------------------------------------
// serial_logic_processor
// Two WIDTH-bit registers combined bit-serially, LSB first, by a run-time
// selectable logic function, with the result routed back into the registers.
// One operation runs per Execute assertion; Execute must drop before the
// next operation can start.
// Ports:
//   Clk      in   system clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   LoadA    in   load Din into A (IDLE only)
//   LoadB    in   load Din into B (IDLE only)
//   Execute  in   start one operation (level, IDLE only)
//   Din      in   load data
//   F        in   function select, latched at operation start
//   R        in   routing select, latched at operation start
//   A, B     out  register contents
//   Busy     out  high while shifting
//   Done     out  one-cycle pulse at operation completion
// -----------------------------------------------------------------------------
module serial_logic_processor
   import slp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             LoadA,
   input  logic             LoadB,
   input  logic             Execute,
   input  logic [WIDTH-1:0] Din,
   input  logic [2:0]       F,
   input  logic [1:0]       R,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_e           state, state_nxt;
   logic [WIDTH-1:0] a_nxt, b_nxt;
   logic             busy_nxt, done_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   func_e            f_q, f_nxt;
   route_e           r_q, r_nxt;
   logic             ina, inb;

   serial_compute_route u_route (
      .a0  (A[0]),
      .b0  (B[0]),
      .F   (f_q),
      .R   (r_q),
      .ina (ina),
      .inb (inb)
   );

   always_comb begin
      state_nxt = state;
      a_nxt     = A;
      b_nxt     = B;
      busy_nxt  = Busy;
      done_nxt  = 1'b0;
      cnt_nxt   = cnt;
      f_nxt     = f_q;
      r_nxt     = r_q;
      case (state)
         ST_IDLE: begin
            // Execute wins over loads in the same cycle.
            if (Execute) begin
               f_nxt     = func_e'(F);
               r_nxt     = route_e'(R);
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
               state_nxt = ST_SHIFT;
            end else begin
               if (LoadA) a_nxt = Din;
               if (LoadB) b_nxt = Din;
            end
         end
         ST_SHIFT: begin
            a_nxt   = {ina, A[WIDTH-1:1]};
            b_nxt   = {inb, B[WIDTH-1:1]};
            cnt_nxt = cnt + CNT_W'(1);
            // cnt holds shifts already done, so WIDTH-1 marks the final shift.
            if (cnt == CNT_W'(WIDTH - 1)) begin
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Waiting for Execute to drop gives one operation per press.
            if (!Execute) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= ST_IDLE;
         A     <= '0;
         B     <= '0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
         cnt   <= '0;
         f_q   <= F_AND;
         r_q   <= R_ROT;
      end else begin
         state <= state_nxt;
         A     <= a_nxt;
         B     <= b_nxt;
         Busy  <= busy_nxt;
         Done  <= done_nxt;
         cnt   <= cnt_nxt;
         f_q   <= f_nxt;
         r_q   <= r_nxt;
      end
   end

endmodule

// File: tb/tb_serial_logic_processor.sv
// -----------------------------------------------------------------------------
// tb_serial_logic_processor
// Self-checking bench: WIDTH=8 instance checked every cycle against a
// word-level model, plus directed literal checks; a WIDTH=16 instance
// checked with a directed operation.
// -----------------------------------------------------------------------------
module tb_serial_logic_processor;

   localparam int W   = 8;
   localparam int W16 = 16;
   localparam int unsigned MASK = 32'h0000_00FF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          load_a, load_b, exe;
   logic [W-1:0]  din;
   logic [2:0]    f;
   logic [1:0]    r;
   logic [W-1:0]  a, b;
   logic          busy, done;

   logic          load_a16, load_b16, exe16;
   logic [W16-1:0] din16;
   logic [2:0]    f16;
   logic [1:0]    r16;
   logic [W16-1:0] a16, b16;
   logic          busy16, done16;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   serial_logic_processor #(.WIDTH(W)) dut (
      .Clk(clk), .Reset_n(rst_n), .LoadA(load_a), .LoadB(load_b),
      .Execute(exe), .Din(din), .F(f), .R(r),
      .A(a), .B(b), .Busy(busy), .Done(done)
   );

   serial_logic_processor #(.WIDTH(W16)) dut16 (
      .Clk(clk), .Reset_n(rst_n), .LoadA(load_a16), .LoadB(load_b16),
      .Execute(exe16), .Din(din16), .F(f16), .R(r16),
      .A(a16), .B(b16), .Busy(busy16), .Done(done16)
   );

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- word-level reference model ----------------
   function automatic int unsigned fn_word(input int fc, input int unsigned x,
                                           input int unsigned y, input int unsigned mask);
      case (fc)
         0:       return x & y;
         1:       return x | y;
         2:       return x ^ y;
         3:       return mask;
         4:       return ~(x & y) & mask;
         5:       return ~(x | y) & mask;
         6:       return ~(x ^ y) & mask;
         default: return 0;
      endcase
   endfunction

   // Final word of A (want_b=0) or B (want_b=1) after a complete operation.
   function automatic int unsigned route_word(input int fc, input int rc,
                                              input int unsigned x, input int unsigned y,
                                              input int unsigned mask, input bit want_b);
      int unsigned fw, ra, rb;
      fw = fn_word(fc, x, y, mask);
      case (rc)
         0:       begin ra = x;  rb = y;  end
         1:       begin ra = x;  rb = fw; end
         2:       begin ra = fw; rb = y;  end
         default: begin ra = y;  rb = x;  end
      endcase
      return want_b ? rb : ra;
   endfunction

   // After n shifts the top n bits hold the low n bits of the final word and
   // the bottom bits hold the original word shifted down by n.
   int unsigned m_a, m_b, m_a0, m_b0, m_fa, m_fb;
   int          m_n;
   bit          m_run, m_hold, m_busy, m_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_a <= 0; m_b <= 0; m_n <= 0;
         m_run <= 0; m_hold <= 0; m_busy <= 0; m_done <= 0;
      end else begin
         m_done <= 0;
         if (m_run) begin
            m_n <= m_n + 1;
            m_a <= ((m_a0 >> (m_n + 1)) | (m_fa << (W - m_n - 1))) & MASK;
            m_b <= ((m_b0 >> (m_n + 1)) | (m_fb << (W - m_n - 1))) & MASK;
            if (m_n + 1 == W) begin
               m_run <= 0; m_hold <= 1; m_busy <= 0; m_done <= 1;
            end
         end else if (m_hold) begin
            if (!exe) m_hold <= 0;
         end else if (exe) begin
            m_a0  <= m_a;
            m_b0  <= m_b;
            m_fa  <= route_word(int'(f), int'(r), m_a, m_b, MASK, 1'b0);
            m_fb  <= route_word(int'(f), int'(r), m_a, m_b, MASK, 1'b1);
            m_n   <= 0;
            m_run <= 1;
            m_busy <= 1;
         end else begin
            if (load_a) m_a <= 32'(din);
            if (load_b) m_b <= 32'(din);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("trace_a",    32'(a),    m_a);
         chk("trace_b",    32'(b),    m_b);
         chk("trace_busy", 32'(busy), 32'(m_busy));
         chk("trace_done", 32'(done), 32'(m_done));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load2(input logic [W-1:0] va, input logic [W-1:0] vb);
      @(negedge clk); din = va; load_a = 1; load_b = 0;
      @(negedge clk); din = vb; load_a = 0; load_b = 1;
      @(negedge clk); load_b = 0;
   endtask

   // Starts an operation, scrambles F/R while it runs, checks Done latency.
   task automatic run_op(input logic [2:0] fc, input logic [1:0] rc);
      int lat;
      @(negedge clk); f = fc; r = rc; exe = 1; lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) chk("busy_at_start", 32'(busy), 1);
         f = 3'($urandom); r = 2'($urandom);
         if (done) begin lat = i; break; end
      end
      exe = 0;
      chk("done_latency", lat, W + 1);
      @(negedge clk);
      chk("done_cleared", 32'(done), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; load_a = 0; load_b = 0; exe = 0; din = '0; f = '0; r = '0;
      load_a16 = 0; load_b16 = 0; exe16 = 0; din16 = '0; f16 = '0; r16 = '0;

      @(negedge clk);
      chk("reset_a",    32'(a),    0);
      chk("reset_b",    32'(b),    0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk_on = 1;
      @(negedge clk); rst_n = 1;

      load2(8'h5A, 8'h3C);
      run_op(3'b000, 2'b10);
      chk("and_to_a_a", 32'(a), 32'h18);
      chk("and_to_a_b", 32'(b), 32'h3C);

      load2(8'h5A, 8'h3C);
      run_op(3'b010, 2'b01);
      chk("xor_to_b_a", 32'(a), 32'h5A);
      chk("xor_to_b_b", 32'(b), 32'h66);

      load2(8'h5A, 8'h3C);
      run_op(3'b000, 2'b11);
      chk("swap_a", 32'(a), 32'h3C);
      chk("swap_b", 32'(b), 32'h5A);
      run_op(3'b011, 2'b00);
      chk("rotate_a", 32'(a), 32'h3C);
      chk("rotate_b", 32'(b), 32'h5A);

      // Execute held for 30 cycles with LoadA toggling: one operation only.
      begin
         int dones;
         dones = 0;
         @(negedge clk); f = 3'b000; r = 2'b00; exe = 1; din = 8'hFF;
         for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) dones++;
            load_a = (i >= 2 && i < 26) ? i[0] : 1'b0;
         end
         chk("held_exe_one_done", dones, 1);
         chk("held_exe_a", 32'(a), 32'h3C);
         chk("held_exe_b", 32'(b), 32'h5A);
         exe = 0;
         @(negedge clk);
         run_op(3'b000, 2'b11);
         chk("second_op_a", 32'(a), 32'h5A);
         chk("second_op_b", 32'(b), 32'h3C);
      end

      // Reset asserted just after the 3rd shift edge.
      @(negedge clk); f = 3'b000; r = 2'b10; exe = 1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #2 rst_n = 0; exe = 0;
      #1;
      chk("midop_reset_a",    32'(a),    0);
      chk("midop_reset_b",    32'(b),    0);
      chk("midop_reset_busy", 32'(busy), 0);
      chk("midop_reset_done", 32'(done), 0);
      @(negedge clk);
      @(negedge clk); rst_n = 1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("no_done_after_reset", 32'(done), 0);
      end
      @(negedge clk); din = 8'hA5; load_a = 1; load_b = 1;
      @(negedge clk); load_a = 0; load_b = 0;
      chk("dual_load_a", 32'(a), 32'hA5);
      chk("dual_load_b", 32'(b), 32'hA5);

      // Randomised operations with loads toggling while busy.
      for (int n = 0; n < 40; n++) begin
         int lat;
         int extra;
         load2(8'($urandom), 8'($urandom));
         @(negedge clk); f = 3'($urandom); r = 2'($urandom); exe = 1; lat = 0;
         for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            f = 3'($urandom); r = 2'($urandom);
            din = 8'($urandom); load_a = 1'($urandom); load_b = 1'($urandom);
            if (done) begin lat = i; break; end
         end
         chk("rand_latency", lat, W + 1);
         extra = $urandom_range(0, 3);
         for (int i = 0; i < extra; i++) begin
            @(negedge clk);
            din = 8'($urandom); load_a = 1'($urandom); load_b = 1'($urandom);
         end
         load_a = 0; load_b = 0; exe = 0;
         @(negedge clk);
      end

      // WIDTH=16 instance.
      begin
         int lat16;
         @(negedge clk); din16 = 16'hFFFF; load_a16 = 1;
         @(negedge clk); din16 = 16'h00F0; load_a16 = 0; load_b16 = 1;
         @(negedge clk); load_b16 = 0; f16 = 3'b110; r16 = 2'b10; exe16 = 1; lat16 = 0;
         for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done16) begin lat16 = i; break; end
         end
         exe16 = 0;
         chk("w16_latency", lat16, W16 + 1);
         chk("w16_a", 32'(a16), 32'h00F0);
         chk("w16_b", 32'(b16), 32'h00F0);
         chk("w16_busy", 32'(busy16), 0);
         @(negedge clk);
         chk("w16_done_cleared", 32'(done16), 0);
      end

      chk_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_logic_processor.md
# serial_logic_processor

Parametrised bit-serial logic processor core: two WIDTH-bit registers A and B, loaded from Din, combined bit-serially (LSB first) by a selectable 2-input logic function, with the results routed back into the registers.
- Successor to the fixed 4/8-bit lab processor.
- F and R are run-time inputs latched per operation, not hardwired.
- Adds Busy/Done status and one-operation-per-press execute semantics.
- Sits below the board top level; that level owns the button synchronisers and hex displays.

## Interface
- WIDTH, 8, register width and shifts per operation; legal range ≥ 2.
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- LoadA  in  1  synchronised, active-high; load Din into A.
- LoadB  in  1  synchronised, active-high; load Din into B.
- Execute  in  1  synchronised, active-high level; start one operation.
- Din  in  WIDTH  load data.
- F  in  3  function select, sampled at operation start.
- R  in  2  routing select, sampled at operation start.
- A  out  WIDTH  register A contents.
- B  out  WIDTH  register B contents.
- Busy  out  1  high while shifting.
- Done  out  1  one-cycle pulse when an operation completes.

## Operation
- Reset (Reset_n low, async): A=0, B=0, Busy=0, Done=0, state IDLE, shift counter 0, latched F/R=0. Reset asserted mid-operation aborts it immediately; no Done is issued.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - Execute=1: latch F/R, clear counter, set Busy, go to SHIFT. Execute has priority; LoadA/LoadB are ignored in that cycle.
  - Otherwise LoadA loads A<=Din and LoadB loads B<=Din. Both asserted loads both.
- SHIFT:
  - Each cycle a0=A[0], b0=B[0], f=F(a0,b0).
  - A<={ina, A[WIDTH-1:1]}, B<={inb, B[WIDTH-1:1]}.
  - Counter increments each shift. On the WIDTH-th shift: Busy<=0, Done<=1, go to HOLD.
  - Loads are ignored. Changes on F and R are ignored.
- HOLD: Done cleared after one cycle. Stay in HOLD while Execute=1; go to IDLE when Execute=0. Loads are ignored in HOLD.
- F coding: 000 AND, 001 OR, 010 XOR, 011 constant 1, 100 NAND, 101 NOR, 110 XNOR, 111 constant 0.
- R coding (ina, inb):
  - 00 (a0, b0): rotate, no change after WIDTH shifts.
  - 01 (a0, f): B<=F(A,B).
  - 10 (f, b0): A<=F(A,B).
  - 11 (b0, a0): swap A and B.
- Counter width is $clog2(WIDTH)+1. No wrap is reachable because the terminal count equals WIDTH.

## Timing
- Execute sampled high in IDLE at edge k:
  - Busy=1 from edge k.
  - Shifts occur at edges k+1 … k+WIDTH.
  - At edge k+WIDTH: Busy=0, Done=1, and final A/B are visible.
  - Done=0 at edge k+WIDTH+1.
- Operation latency is WIDTH+1 edges from the Execute sample to Done.
- Earliest next operation: Execute low for at least one edge in HOLD returns to IDLE; Execute high sampled there starts a new operation.
- A load asserted at edge j in IDLE is visible on A/B after edge j.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package slp_pkg:
  - enum logic [2:0] for F codes.
  - enum logic [1:0] for R codes.
  - enum for FSM states IDLE/SHIFT/HOLD.
- Sub-module serial_compute_route, combinational:
  - Inputs: a0, b0, F, R.
  - Outputs: ina, inb.
- Register, counter and FSM logic live in serial_logic_processor.

## Test plan
- WIDTH=8; load A=0x5A, B=0x3C; F=000, R=10; Execute high → Busy for 8 cycles, Done pulse at edge k+8, A=0x18, B=0x3C.
- Same loads; F=010, R=01 → A=0x5A, B=0x66.
- Same loads; R=11 → A=0x3C, B=0x5A. Then R=00, F=011 → registers unchanged.
- Hold Execute high 30 cycles → exactly one operation and one Done. Toggle LoadA with Din=0xFF during SHIFT/HOLD → A unaffected. Release and reassert Execute → second operation runs.
- Reset_n low at the 3rd shift edge → A=B=0 and Busy=0 immediately (async), no Done. After release, LoadA and LoadB asserted together with Din=0xA5 → A=B=0xA5.
- WIDTH=16; A=0xFFFF, B=0x00F0; F=110, R=10 → A=0x00F0 after 16 shifts, Done at edge k+16.
